pipe_mul_sm: RTL

- Parametrised, pipelined signed multiplier for the FIR tap datapath. It is the registered successor of the combinational sign-magnitude multiplier.
- Converts both operands to sign/magnitude, forms the unsigned magnitude product as two partial products, then re-applies the sign.
- Optionally rounds and saturates to a narrower output.
- Carries valid/ready flow control so FIR taps can stall without losing samples.

---
 rtl/fir_pkg.sv | 46 ++++
 rtl/pipe_mul_sm_if.sv | 30 +++
 rtl/pipe_mul_sm_mag_mul_split.sv | 42 ++++
 rtl/pipe_mul_sm.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap datapath.
//   DW_DEF / OW_DEF : default operand / result widths
//   split_h()       : partial-product split point for a DW-bit magnitude
//   sat_signed()    : re-apply sign to a magnitude and limit it to ow bits
package fir_pkg;

  localparam int unsigned DW_DEF = 13;
  localparam int unsigned OW_DEF = 26;

  // Working width of sat_signed; covers products of operands up to 32 bits.
  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] value;  // two's complement, sign-extended to SAT_W
    logic             ovf;
  } sat_res_t;

  // Low half of the B magnitude is split_h bits wide (floor of dw/2).
  function automatic int unsigned split_h(input int unsigned dw);
    return dw / 2;
  endfunction

  // Sign-apply and range-limit a magnitude to an ow-bit signed result.
  // With sat_en=0 the full signed value is returned so the caller's
  // truncation to ow bits gives the wrapped result; ovf is reported anyway.
  function automatic sat_res_t sat_signed(input logic [SAT_W-1:0] mag,
                                          input logic             sign,
                                          input int unsigned      ow,
                                          input logic             sat_en);
    logic [SAT_W-1:0] pos_lim;
    logic [SAT_W-1:0] neg_lim;
    logic             over;
    sat_res_t         r;
    pos_lim = (SAT_W'(1) << (ow - 1)) - SAT_W'(1);
    neg_lim = SAT_W'(1) << (ow - 1);
    over    = sign ? (mag > neg_lim) : (mag > pos_lim);
    r.ovf   = over;
    if (over && sat_en) begin
      r.value = sign ? (SAT_W'(0) - neg_lim) : pos_lim;
    end else begin
      r.value = sign ? (SAT_W'(0) - mag) : mag;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_mul_sm_if.sv
// Operand/result stream bundle for pipe_mul_sm.
//   in_valid/in_ready   : operand handshake, din1/din2 signed operands
//   out_valid/out_ready : result handshake, dout signed result, ovf flag
//   master : producer of operands and consumer of results (the FIR tap)
//   slave  : the multiplier
interface pipe_mul_sm_if import fir_pkg::*; #(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned OW = OW_DEF
);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] din1;
  logic signed [DW-1:0] din2;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] dout;
  logic                 ovf;

  modport master (
    output in_valid, din1, din2, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din1, din2, out_ready,
    output in_ready, out_valid, dout, ovf
  );

endinterface

// File: rtl/pipe_mul_sm_mag_mul_split.sv
// Registered unsigned DW x DW magnitude multiplier, split into two partial
// products on the B operand at H = floor(DW/2).
//   clk, rst : clock, asynchronous active-high reset
//   en       : stage enable; registers hold while low
//   mag_a    : DW-bit unsigned magnitude A
//   mag_b    : DW-bit unsigned magnitude B
//   pp_lo    : mag_a * mag_b[H-1:0]        (DW+H bits)
//   pp_hi    : mag_a * mag_b[DW-1:H]       (2*DW-H bits)
module mag_mul_split import fir_pkg::*; #(
  parameter  int unsigned DW = DW_DEF,
  localparam int unsigned H  = split_h(DW)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DW-1:0]       mag_a,
  input  logic [DW-1:0]       mag_b,
  output logic [DW+H-1:0]     pp_lo,
  output logic [2*DW-H-1:0]   pp_hi
);

  localparam int unsigned LOW = DW + H;
  localparam int unsigned HIW = 2 * DW - H;

  logic [LOW-1:0] pp_lo_c;
  logic [HIW-1:0] pp_hi_c;

  // Operands widened to the product width before multiplying.
  assign pp_lo_c = LOW'(mag_a) * LOW'(mag_b[H-1:0]);
  assign pp_hi_c = HIW'(mag_a) * HIW'(mag_b[DW-1:H]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_lo <= '0;
      pp_hi <= '0;
    end else if (en) begin
      pp_lo <= pp_lo_c;
      pp_hi <= pp_hi_c;
    end
  end

endmodule

// File: rtl/pipe_mul_sm.sv
// Four-stage pipelined sign-magnitude multiplier with optional rounding and
// saturation, and valid/ready flow control driven by one global enable.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pipe_mul_sm_if
//              in_valid/in_ready/din1/din2   operand stream
//              out_valid/out_ready/dout/ovf  result stream
// Stages: S1 magnitudes+sign+zero, S2 partial products, S3 sum and round,
// S4 sign-apply and limit (output register).
module pipe_mul_sm import fir_pkg::*; #(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned OW     = OW_DEF,
  parameter int unsigned SHIFT  = 0,
  parameter bit          SAT_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  pipe_mul_sm_if.slave bus
);

  localparam int unsigned H   = split_h(DW);
  localparam int unsigned PW  = 2 * DW;
  localparam int unsigned LOW = DW + H;
  localparam int unsigned HIW = PW - H;

  logic adv;

  // Stage valid bits; out_valid_q is the S4 valid.
  logic v1, v2, v3, out_valid_q;

  logic [DW-1:0]  a_u, b_u, abs_a, abs_b;
  logic [DW-1:0]  mag_a1, mag_b1;
  logic           sign1, zero1;

  logic [LOW-1:0] pp_lo2;
  logic [HIW-1:0] pp_hi2;
  logic           sign2, zero2;

  logic [PW-1:0]  mag_sum, magr_c;
  logic [PW-1:0]  magr3;
  logic           sign3, zero3;

  sat_res_t             res;
  logic signed [OW-1:0] dout_c;
  logic signed [OW-1:0] dout_q;
  logic                 ovf_q;

  // Whole pipeline moves together; a held result freezes every stage.
  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.ovf       = ovf_q;

  // S1: two's complement to magnitude; -2^(DW-1) becomes 2^(DW-1) unsigned.
  assign a_u   = bus.din1;
  assign b_u   = bus.din2;
  assign abs_a = a_u[DW-1] ? (~a_u + DW'(1)) : a_u;
  assign abs_b = b_u[DW-1] ? (~b_u + DW'(1)) : b_u;

  // S2: partial products, registered inside the sub-module.
  mag_mul_split #(.DW(DW)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .en    (adv),
    .mag_a (mag_a1),
    .mag_b (mag_b1),
    .pp_lo (pp_lo2),
    .pp_hi (pp_hi2)
  );

  // S3: recombine and round half away from zero on the magnitude.
  assign mag_sum = PW'(pp_lo2) + (PW'(pp_hi2) << H);

  generate
    if (SHIFT > 0) begin : g_round
      logic [PW:0] rnd;
      assign rnd    = {1'b0, mag_sum} + ((PW + 1)'(1) << (SHIFT - 1));
      assign magr_c = PW'(rnd >> SHIFT);
    end else begin : g_exact
      assign magr_c = mag_sum;
    end
  endgenerate

  // S4: sign-apply and limit.
  assign res    = sat_signed(SAT_W'(magr3), sign3, OW, SAT_EN);
  assign dout_c = OW'(res.value);

  // Bits above the result must be pure sign extension unless the value was
  // flagged as wrapped.
  always_comb begin : s4_ext_chk
    assert (res.ovf || (&res.value[SAT_W-1:OW-1]) || !(|res.value[SAT_W-1:OW-1]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      out_valid_q <= 1'b0;
      mag_a1      <= '0;
      mag_b1      <= '0;
      sign1       <= 1'b0;
      zero1       <= 1'b0;
      sign2       <= 1'b0;
      zero2       <= 1'b0;
      magr3       <= '0;
      sign3       <= 1'b0;
      zero3       <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      v1          <= bus.in_valid;
      mag_a1      <= abs_a;
      mag_b1      <= abs_b;
      sign1       <= a_u[DW-1] ^ b_u[DW-1];
      zero1       <= (a_u == '0) || (b_u == '0);

      v2          <= v1;
      sign2       <= sign1;
      zero2       <= zero1;

      v3          <= v2;
      magr3       <= magr_c;
      sign3       <= sign2;
      zero3       <= zero2;

      out_valid_q <= v3;
      dout_q      <= zero3 ? '0 : dout_c;
      ovf_q       <= !zero3 && res.ovf;
    end
  end

endmodule
